// File: rtl/detector_pulse_conditioner_if.sv
// Detector front-end bundle: four raw detector lines and the counter clear
// go in, four conditioned windows and four pile-up drop counters come out.
interface detector_pulse_conditioner_if #(
    parameter int DROP_W = 8
);
    logic              A;
    logic              B;
    logic              BP;
    logic              AP;
    logic              drop_clr;
    logic              win_A;
    logic              win_B;
    logic              win_BP;
    logic              win_AP;
    logic [DROP_W-1:0] drop_cnt_A;
    logic [DROP_W-1:0] drop_cnt_B;
    logic [DROP_W-1:0] drop_cnt_BP;
    logic [DROP_W-1:0] drop_cnt_AP;

    // Source of the detector lines and clear (bench / upstream glue)
    modport master (
        output A, B, BP, AP, drop_clr,
        input  win_A, win_B, win_BP, win_AP,
        input  drop_cnt_A, drop_cnt_B, drop_cnt_BP, drop_cnt_AP
    );

    // The conditioner itself
    modport slave (
        input  A, B, BP, AP, drop_clr,
        output win_A, win_B, win_BP, win_AP,
        output drop_cnt_A, drop_cnt_B, drop_cnt_BP, drop_cnt_AP
    );
endinterface

// File: rtl/detector_pulse_conditioner.sv
// Detector pulse conditioner: synchronises four raw detector lines, turns each
// accepted rising edge into a fixed-width window followed by a dead time, and
// counts edges rejected during lockout in saturating per-channel counters.
// Optional build macro GLITCH_FILTER_EN inserts a 2-sample deglitch stage
// after the synchroniser (one extra cycle of latency and of arming).
module detector_pulse_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH_CYC   = 4,
    parameter int DEAD_CYC    = 8,
    parameter int DROP_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    detector_pulse_conditioner_if.slave bus
);
`ifdef GLITCH_FILTER_EN
    localparam int ARM_CYC = SYNC_STAGES + 2;
`else
    localparam int ARM_CYC = SYNC_STAGES + 1;
`endif
    localparam int AW       = $clog2(ARM_CYC + 1);
    localparam int CW       = $clog2(DEAD_CYC + 1);
    localparam int DEAD_LEN = DEAD_CYC - WIDTH_CYC;

    typedef enum logic [1:0] {IDLE, WINDOW, DEAD} state_t;

    logic [3:0]        raw;
    logic [3:0]        win_reg;
    logic [DROP_W-1:0] drop_reg [4];
    logic [AW-1:0]     arm_reg;
    logic              armed;

    assign raw   = {bus.AP, bus.BP, bus.B, bus.A};
    assign armed = (arm_reg == AW'(ARM_CYC));

    // Arming counter: suppress edge detection while synchronisers refill after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_reg <= '0;
        end else if (!armed) begin
            arm_reg <= arm_reg + AW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_out;
            logic                   prev_reg;
            logic                   level;
            logic                   edge_det;
            logic                   edge_ok;
            logic                   reject;
            state_t                 state_reg;
            logic [CW-1:0]          cnt_reg;

            assign sync_out = sync_reg[SYNC_STAGES-1];

            // Synchroniser chain for the asynchronous detector line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
                end
            end

`ifdef GLITCH_FILTER_EN
            logic sync_last_reg;

            // Previous synchroniser output, for the two-sample agreement test
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_last_reg <= 1'b0;
                end else begin
                    sync_last_reg <= sync_out;
                end
            end

            // Filtered level changes only when two consecutive samples agree,
            // otherwise it holds the last filtered level (kept in prev_reg)
            always_comb begin
                level = prev_reg;
                if (sync_out && sync_last_reg) begin
                    level = 1'b1;
                end else if (!sync_out && !sync_last_reg) begin
                    level = 1'b0;
                end
            end
`else
            assign level = sync_out;
`endif

            assign edge_det = level & ~prev_reg;
            assign edge_ok  = edge_det & armed;
            assign reject   = edge_ok & (state_reg != IDLE);

            // Previous level, for rising-edge detection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= level;
                end
            end

            // Window / dead-time FSM; only an edge seen in IDLE opens a window
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    win_reg[gi] <= 1'b0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (edge_ok) begin
                                state_reg   <= WINDOW;
                                cnt_reg     <= '0;
                                win_reg[gi] <= 1'b1;
                            end
                        end
                        WINDOW: begin
                            if (cnt_reg == CW'(WIDTH_CYC - 1)) begin
                                win_reg[gi] <= 1'b0;
                                cnt_reg     <= '0;
                                state_reg   <= (DEAD_LEN == 0) ? IDLE : DEAD;
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                        DEAD: begin
                            if (cnt_reg == CW'(DEAD_LEN - 1)) begin
                                cnt_reg   <= '0;
                                state_reg <= IDLE;
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                        default: begin
                            state_reg   <= IDLE;
                            cnt_reg     <= '0;
                            win_reg[gi] <= 1'b0;
                        end
                    endcase
                end
            end

            // Saturating pile-up counter; a clear overrides a same-cycle rejection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    drop_reg[gi] <= '0;
                end else if (bus.drop_clr) begin
                    drop_reg[gi] <= '0;
                end else if (reject && (drop_reg[gi] != {DROP_W{1'b1}})) begin
                    drop_reg[gi] <= drop_reg[gi] + DROP_W'(1);
                end
            end
        end
    endgenerate

    assign bus.win_A       = win_reg[0];
    assign bus.win_B       = win_reg[1];
    assign bus.win_BP      = win_reg[2];
    assign bus.win_AP      = win_reg[3];
    assign bus.drop_cnt_A  = drop_reg[0];
    assign bus.drop_cnt_B  = drop_reg[1];
    assign bus.drop_cnt_BP = drop_reg[2];
    assign bus.drop_cnt_AP = drop_reg[3];
endmodule
